// File: rtl/controlador_jogo_if.sv
// Lookup and attack-matrix write bus between the game sequencer and the map/matrix storage.
// The master side (sequencer) issues the lookup and the write strobe; the slave answers.
interface controlador_jogo_if;
   logic       consulta_req;
   logic [2:0] consulta_col;
   logic [2:0] consulta_lin;
   logic       consulta_ack;
   logic       consulta_acerto;
   logic       tiro_we;
   logic       tiro_acerto;

   modport master (
      output consulta_req, consulta_col, consulta_lin, tiro_we, tiro_acerto,
      input  consulta_ack, consulta_acerto
   );

   modport slave (
      input  consulta_req, consulta_col, consulta_lin, tiro_we, tiro_acerto,
      output consulta_ack, consulta_acerto
   );
endinterface

// File: rtl/controlador_jogo.sv
// Battleship game sequencer: mode decode, shot gating, map lookup handshake, lives/hits.
// Define HIST_TIROS_EN to keep a 35-cell shot history that rejects repeated shots.
module controlador_jogo #(
   parameter int VIDAS_INI = 3,
   parameter int ALVOS     = 6
) (
   input  logic                   clock_in,
   input  logic                   reset_n,
   input  logic [1:0]             modo,
   input  logic                   confirmar,
   input  logic [2:0]             coord_coluna,
   input  logic [2:0]             coord_linha,
   input  logic                   mapa_ok,
   controlador_jogo_if.master     bus,
   output logic [1:0]             vida,
   output logic [3:0]             acertos,
   output logic [2:0]             estado,
   output logic                   LED_R,
   output logic                   LED_G,
   output logic                   LED_B
);

   localparam logic [2:0] DESLIGADO  = 3'd0;
   localparam logic [2:0] PREPARACAO = 3'd1;
   localparam logic [2:0] ESPERA     = 3'd2;
   localparam logic [2:0] CONSULTA   = 3'd3;
   localparam logic [2:0] ATUALIZA   = 3'd4;
   localparam logic [2:0] VITORIA    = 3'd5;
   localparam logic [2:0] DERROTA    = 3'd6;

   logic       acerto_r;
   logic [2:0] col_r;
   logic [2:0] lin_r;
   logic       coord_ok;
   logic       repetido;
   logic       entra_prep;
   logic       grava;
   logic [3:0] acertos_inc;
   logic [1:0] vida_dec;

   // A lookup in flight always completes before preparation can restart the game.
   assign entra_prep  = (modo == 2'b01) && (estado != CONSULTA) && (estado != ATUALIZA);
   assign grava       = (estado == ATUALIZA) && (modo != 2'b00);
   assign coord_ok    = (coord_coluna <= 3'd4) && (coord_linha <= 3'd6);
   assign acertos_inc = (acertos == 4'hF) ? acertos : acertos + 4'd1;
   assign vida_dec    = (vida == 2'd0) ? 2'd0 : vida - 2'd1;

   assign bus.consulta_req = (estado == CONSULTA);
   assign bus.consulta_col = col_r;
   assign bus.consulta_lin = lin_r;
   assign bus.tiro_we      = grava;
   assign bus.tiro_acerto  = acerto_r;

`ifdef HIST_TIROS_EN
   logic [34:0] hist;
   logic [5:0]  idx_in;
   logic [5:0]  idx_r;

   assign idx_in   = {3'b000, coord_linha} * 6'd5 + {3'b000, coord_coluna};
   assign idx_r    = {3'b000, lin_r} * 6'd5 + {3'b000, col_r};
   assign repetido = coord_ok && hist[idx_in];

   // Cells are marked only once the write actually happens.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         hist <= '0;
      end else if (entra_prep) begin
         hist <= '0;
      end else if (grava) begin
         hist[idx_r] <= 1'b1;
      end
   end
`else
   assign repetido = 1'b0;
`endif

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         estado   <= DESLIGADO;
         vida     <= 2'd0;
         acertos  <= 4'd0;
         LED_R    <= 1'b0;
         LED_G    <= 1'b0;
         LED_B    <= 1'b0;
         col_r    <= 3'd0;
         lin_r    <= 3'd0;
         acerto_r <= 1'b0;
      end else if (modo == 2'b00) begin
         estado <= DESLIGADO;
      end else if (entra_prep) begin
         estado  <= PREPARACAO;
         vida    <= VIDAS_INI[1:0];
         acertos <= 4'd0;
         {LED_R, LED_G, LED_B} <= 3'b000;
      end else begin
         case (estado)
            PREPARACAO: begin
               if (modo[1]) begin
                  if (mapa_ok) estado <= ESPERA;
                  else         {LED_R, LED_G, LED_B} <= 3'b001;
               end
            end
            ESPERA: begin
               if (confirmar) begin
                  if (coord_ok && !repetido) begin
                     col_r  <= coord_coluna;
                     lin_r  <= coord_linha;
                     estado <= CONSULTA;
                  end else begin
                     {LED_R, LED_G, LED_B} <= 3'b001;
                  end
               end
            end
            CONSULTA: begin
               if (bus.consulta_ack) begin
                  acerto_r <= bus.consulta_acerto;
                  estado   <= ATUALIZA;
               end
            end
            ATUALIZA: begin
               if (acerto_r) begin
                  acertos <= acertos_inc;
                  {LED_R, LED_G, LED_B} <= 3'b010;
                  estado <= (acertos_inc == ALVOS[3:0]) ? VITORIA : ESPERA;
               end else begin
                  vida <= vida_dec;
                  {LED_R, LED_G, LED_B} <= 3'b100;
                  estado <= (vida_dec == 2'd0) ? DERROTA : ESPERA;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_controlador_jogo.sv
// Self-checking bench for controlador_jogo: a directed vector table for the main flow
// plus hand-written sequences for victory, abort, reset and repeated shots.
module tb_controlador_jogo;

   logic       clock_in = 1'b0;
   logic       reset_n;
   logic [1:0] modo;
   logic       confirmar;
   logic [2:0] coord_coluna;
   logic [2:0] coord_linha;
   logic       mapa_ok;
   logic [1:0] vida;
   logic [3:0] acertos;
   logic [2:0] estado;
   logic       LED_R;
   logic       LED_G;
   logic       LED_B;

   int checks = 0;
   int errors = 0;

   controlador_jogo_if bus();

   controlador_jogo dut (
      .clock_in     (clock_in),
      .reset_n      (reset_n),
      .modo         (modo),
      .confirmar    (confirmar),
      .coord_coluna (coord_coluna),
      .coord_linha  (coord_linha),
      .mapa_ok      (mapa_ok),
      .bus          (bus),
      .vida         (vida),
      .acertos      (acertos),
      .estado       (estado),
      .LED_R        (LED_R),
      .LED_G        (LED_G),
      .LED_B        (LED_B)
   );

   always #5 clock_in = ~clock_in;

   typedef struct {
      logic [1:0] modo;
      logic       conf;
      logic [2:0] col;
      logic [2:0] lin;
      logic       mapa;
      logic       ack;
      logic       hit;
      logic [2:0] e_estado;
      logic       e_req;
      logic       e_we;
      logic [1:0] e_vida;
      logic [3:0] e_acertos;
      logic [2:0] e_leds;
   } vec_t;

   vec_t vecs[22];

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clock_in);
      #1;
   endtask

   task automatic apply_stimulus(input vec_t v);
      modo                = v.modo;
      confirmar           = v.conf;
      coord_coluna        = v.col;
      coord_linha         = v.lin;
      mapa_ok             = v.mapa;
      bus.consulta_ack    = v.ack;
      bus.consulta_acerto = v.hit;
   endtask

   task automatic idle_inputs();
      confirmar           = 1'b0;
      bus.consulta_ack    = 1'b0;
      bus.consulta_acerto = 1'b0;
   endtask

   // One full shot: confirm, hold the lookup for 'delay' cycles, then ack.
   task automatic do_shot(input logic [2:0] c, input logic [2:0] l, input logic hit,
                          input int delay, input string name);
      confirmar    = 1'b1;
      coord_coluna = c;
      coord_linha  = l;
      step();
      confirmar = 1'b0;
      check_output({name, ".estado_consulta"}, estado, 3);
      check_output({name, ".req"}, bus.consulta_req, 1);
      for (int k = 0; k < delay; k++) begin
         step();
         check_output({name, ".req_held"}, bus.consulta_req, 1);
      end
      bus.consulta_ack    = 1'b1;
      bus.consulta_acerto = hit;
      step();
      idle_inputs();
      check_output({name, ".we"}, bus.tiro_we, 1);
      check_output({name, ".tiro_acerto"}, bus.tiro_acerto, hit);
      check_output({name, ".col"}, bus.consulta_col, c);
      check_output({name, ".lin"}, bus.consulta_lin, l);
      step();
      check_output({name, ".we_drop"}, bus.tiro_we, 0);
   endtask

   task automatic start_attack();
      modo    = 2'b01;
      mapa_ok = 1'b1;
      step();
      modo = 2'b10;
      step();
      check_output("start.estado", estado, 2);
   endtask

   initial begin
      vecs[0]  = '{2'd1,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0, 3'd1,1'b0,1'b0,2'd3,4'd0,3'b000};
      vecs[1]  = '{2'd2,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0, 3'd1,1'b0,1'b0,2'd3,4'd0,3'b001};
      vecs[2]  = '{2'd2,1'b0,3'd0,3'd0,1'b1,1'b0,1'b0, 3'd2,1'b0,1'b0,2'd3,4'd0,3'b001};
      vecs[3]  = '{2'd2,1'b1,3'd2,3'd3,1'b1,1'b0,1'b0, 3'd3,1'b1,1'b0,2'd3,4'd0,3'b001};
      vecs[4]  = '{2'd2,1'b0,3'd0,3'd0,1'b1,1'b0,1'b0, 3'd3,1'b1,1'b0,2'd3,4'd0,3'b001};
      vecs[5]  = '{2'd2,1'b0,3'd0,3'd0,1'b1,1'b1,1'b1, 3'd4,1'b0,1'b1,2'd3,4'd0,3'b001};
      vecs[6]  = '{2'd2,1'b0,3'd0,3'd0,1'b1,1'b0,1'b0, 3'd2,1'b0,1'b0,2'd3,4'd1,3'b010};
      vecs[7]  = '{2'd2,1'b1,3'd5,3'd0,1'b1,1'b0,1'b0, 3'd2,1'b0,1'b0,2'd3,4'd1,3'b001};
      vecs[8]  = '{2'd2,1'b1,3'd0,3'd7,1'b1,1'b0,1'b0, 3'd2,1'b0,1'b0,2'd3,4'd1,3'b001};
      vecs[9]  = '{2'd2,1'b0,3'd0,3'd0,1'b1,1'b1,1'b1, 3'd2,1'b0,1'b0,2'd3,4'd1,3'b001};
      vecs[10] = '{2'd2,1'b1,3'd0,3'd0,1'b1,1'b1,1'b1, 3'd3,1'b1,1'b0,2'd3,4'd1,3'b001};
      vecs[11] = '{2'd2,1'b0,3'd0,3'd0,1'b1,1'b1,1'b0, 3'd4,1'b0,1'b1,2'd3,4'd1,3'b001};
      vecs[12] = '{2'd2,1'b0,3'd0,3'd0,1'b1,1'b0,1'b0, 3'd2,1'b0,1'b0,2'd2,4'd1,3'b100};
      vecs[13] = '{2'd3,1'b1,3'd4,3'd6,1'b1,1'b0,1'b0, 3'd3,1'b1,1'b0,2'd2,4'd1,3'b100};
      vecs[14] = '{2'd3,1'b0,3'd0,3'd0,1'b1,1'b1,1'b0, 3'd4,1'b0,1'b1,2'd2,4'd1,3'b100};
      vecs[15] = '{2'd3,1'b0,3'd0,3'd0,1'b1,1'b0,1'b0, 3'd2,1'b0,1'b0,2'd1,4'd1,3'b100};
      vecs[16] = '{2'd2,1'b1,3'd1,3'd2,1'b1,1'b0,1'b0, 3'd3,1'b1,1'b0,2'd1,4'd1,3'b100};
      vecs[17] = '{2'd1,1'b0,3'd0,3'd0,1'b1,1'b0,1'b0, 3'd3,1'b1,1'b0,2'd1,4'd1,3'b100};
      vecs[18] = '{2'd1,1'b0,3'd0,3'd0,1'b1,1'b1,1'b0, 3'd4,1'b0,1'b1,2'd1,4'd1,3'b100};
      vecs[19] = '{2'd1,1'b0,3'd0,3'd0,1'b1,1'b0,1'b0, 3'd6,1'b0,1'b0,2'd0,4'd1,3'b100};
      vecs[20] = '{2'd2,1'b1,3'd3,3'd3,1'b1,1'b0,1'b0, 3'd6,1'b0,1'b0,2'd0,4'd1,3'b100};
      vecs[21] = '{2'd1,1'b0,3'd0,3'd0,1'b1,1'b0,1'b0, 3'd1,1'b0,1'b0,2'd3,4'd0,3'b000};

      reset_n      = 1'b0;
      modo         = 2'b00;
      mapa_ok      = 1'b0;
      coord_coluna = 3'd0;
      coord_linha  = 3'd0;
      idle_inputs();
      repeat (2) step();
      check_output("reset.estado", estado, 0);
      check_output("reset.vida", vida, 0);
      check_output("reset.acertos", acertos, 0);
      check_output("reset.req", bus.consulta_req, 0);
      check_output("reset.we", bus.tiro_we, 0);
      check_output("reset.leds", {LED_R, LED_G, LED_B}, 0);
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 22; i++) begin
         apply_stimulus(vecs[i]);
         step();
         check_output($sformatf("vec%0d.estado", i), estado, vecs[i].e_estado);
         check_output($sformatf("vec%0d.req", i), bus.consulta_req, vecs[i].e_req);
         check_output($sformatf("vec%0d.we", i), bus.tiro_we, vecs[i].e_we);
         check_output($sformatf("vec%0d.vida", i), vida, vecs[i].e_vida);
         check_output($sformatf("vec%0d.acertos", i), acertos, vecs[i].e_acertos);
         check_output($sformatf("vec%0d.leds", i), {LED_R, LED_G, LED_B}, vecs[i].e_leds);
      end
      idle_inputs();

      // Six distinct hits reach VITORIA; later confirms are ignored.
      start_attack();
      do_shot(3'd0, 3'd0, 1'b1, 0, "win1");
      do_shot(3'd1, 3'd1, 1'b1, 2, "win2");
      do_shot(3'd2, 3'd2, 1'b1, 0, "win3");
      do_shot(3'd3, 3'd3, 1'b1, 1, "win4");
      do_shot(3'd4, 3'd4, 1'b1, 0, "win5");
      check_output("win5.estado", estado, 2);
      do_shot(3'd0, 3'd5, 1'b1, 0, "win6");
      check_output("win.estado", estado, 5);
      check_output("win.acertos", acertos, 6);
      check_output("win.leds", {LED_R, LED_G, LED_B}, 3'b010);
      confirmar    = 1'b1;
      coord_coluna = 3'd1;
      coord_linha  = 3'd0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_output("win_after.req", bus.consulta_req, 0);
         check_output("win_after.we", bus.tiro_we, 0);
         check_output("win_after.estado", estado, 5);
      end
      confirmar = 1'b0;

      // modo 00 while a lookup is pending aborts it without a write.
      start_attack();
      confirmar    = 1'b1;
      coord_coluna = 3'd3;
      coord_linha  = 3'd3;
      step();
      confirmar = 1'b0;
      check_output("abort.estado_consulta", estado, 3);
      modo                = 2'b00;
      bus.consulta_ack    = 1'b1;
      bus.consulta_acerto = 1'b1;
      step();
      idle_inputs();
      check_output("abort.estado", estado, 0);
      check_output("abort.req", bus.consulta_req, 0);
      check_output("abort.we", bus.tiro_we, 0);
      step();
      check_output("abort.we_later", bus.tiro_we, 0);
      check_output("abort.acertos", acertos, 0);

      // Asynchronous reset in the middle of a lookup.
      start_attack();
      confirmar    = 1'b1;
      coord_coluna = 3'd1;
      coord_linha  = 3'd4;
      step();
      confirmar = 1'b0;
      check_output("rst_mid.estado_consulta", estado, 3);
      #2 reset_n = 1'b0;
      #1;
      check_output("rst_mid.estado", estado, 0);
      check_output("rst_mid.req", bus.consulta_req, 0);
      check_output("rst_mid.vida", vida, 0);
      check_output("rst_mid.acertos", acertos, 0);
      step();
      reset_n = 1'b1;

      // Repeat shot on the same cell.
      start_attack();
      do_shot(3'd1, 3'd1, 1'b1, 0, "rep1");
      check_output("rep1.acertos", acertos, 1);
`ifdef HIST_TIROS_EN
      confirmar    = 1'b1;
      coord_coluna = 3'd1;
      coord_linha  = 3'd1;
      step();
      confirmar = 1'b0;
      check_output("rep2.estado", estado, 2);
      check_output("rep2.req", bus.consulta_req, 0);
      check_output("rep2.leds", {LED_R, LED_G, LED_B}, 3'b001);
      step();
      check_output("rep2.we", bus.tiro_we, 0);
      check_output("rep2.acertos", acertos, 1);
`else
      do_shot(3'd1, 3'd1, 1'b1, 0, "rep2");
      check_output("rep2.acertos", acertos, 2);
      check_output("rep2.leds", {LED_R, LED_G, LED_B}, 3'b010);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
